// File: rtl/modexp_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : modexp_pkg
// Description : Shared types and index-width helper for the modexp sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package modexp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SQR  = 3'd2,
        ST_MUL  = 3'd3,
        ST_POST = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // Every multiplier operation is an ISSUE cycle followed by WAIT cycles.
    typedef enum logic {
        PH_ISSUE = 1'b0,
        PH_WAIT  = 1'b1
    } phase_e;

    localparam int EXP_WIDTH_DEF = 1024;
    localparam int IDX_W         = $clog2(EXP_WIDTH_DEF) + 1;

    function automatic int idx_width(input int exp_width);
        return $clog2(exp_width) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mm_issue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mm_issue
// Description : Start/done handshake helper for the Montgomery multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_issue #(
    parameter int WIDTH = 1024
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_req,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_m,
    output logic             o_mm_start,
    output logic [WIDTH-1:0] o_mm_a,
    output logic [WIDTH-1:0] o_mm_b,
    output logic [WIDTH-1:0] o_mm_m,
    input  logic [WIDTH-1:0] i_mm_result,
    input  logic             i_mm_done,
    output logic             o_ack,
    output logic [WIDTH-1:0] o_result
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_m;
    logic             r_wait;
    logic             w_fire;

    // A request while an op is outstanding is refused rather than re-issued.
    assign w_fire = i_req & ~r_wait;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a    <= '0;
            r_b    <= '0;
            r_m    <= '0;
            r_wait <= 1'b0;
        end else if (w_fire) begin
            r_a    <= i_a;
            r_b    <= i_b;
            r_m    <= i_m;
            r_wait <= 1'b1;
        end else if (r_wait && i_mm_done) begin
            r_wait <= 1'b0;
        end
    end

    // Operands pass straight through in the issue cycle, then come from the hold registers.
    assign o_mm_start = w_fire;
    assign o_mm_a     = w_fire ? i_a : r_a;
    assign o_mm_b     = w_fire ? i_b : r_b;
    assign o_mm_m     = w_fire ? i_m : r_m;
    assign o_ack      = r_wait & i_mm_done;
    assign o_result   = i_mm_result;

endmodule

`default_nettype wire

// File: rtl/modexp_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : modexp_ctrl
// Description : Left-to-right square-and-multiply sequencer computing x^e mod M.
// Revision    : 1.0 - initial release
// ============================================================================
module modexp_ctrl
    import modexp_pkg::*;
#(
    parameter int WIDTH     = 1024,
    parameter int EXP_WIDTH = 1024
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       start,
    input  logic [WIDTH-1:0]           in_x,
    input  logic [EXP_WIDTH-1:0]       in_e,
    input  logic [$clog2(EXP_WIDTH):0] in_t,
    input  logic [WIDTH-1:0]           in_m,
    input  logic [WIDTH-1:0]           in_r_mod_m,
    input  logic [WIDTH-1:0]           in_r2_mod_m,
    output logic                       mm_start,
    output logic [WIDTH-1:0]           mm_a,
    output logic [WIDTH-1:0]           mm_b,
    output logic [WIDTH-1:0]           mm_m,
    input  logic [WIDTH-1:0]           mm_result,
    input  logic                       mm_done,
    output logic [WIDTH-1:0]           result,
    output logic                       done,
    output logic                       busy
);

    localparam int                 C_IDX_W   = idx_width(EXP_WIDTH);
    localparam logic [C_IDX_W-1:0] C_T_MAX   = C_IDX_W'(EXP_WIDTH);
    localparam logic [C_IDX_W-1:0] C_IDX_ONE = {{(C_IDX_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   C_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e                 r_state;
    state_e                 w_state_nxt;
    phase_e                 r_phase;
    phase_e                 w_phase_nxt;
    logic [WIDTH-1:0]       r_x;
    logic [WIDTH-1:0]       r_m;
    logic [WIDTH-1:0]       r_r2;
    logic [WIDTH-1:0]       r_acc;
    logic [WIDTH-1:0]       r_xm;
    logic [WIDTH-1:0]       r_result;
    logic [EXP_WIDTH-1:0]   r_e;
    logic [C_IDX_W-1:0]     r_i;
    logic [C_IDX_W-1:0]     w_i_dec;
    logic [C_IDX_W-1:0]     w_t_clamp;
    logic [EXP_WIDTH-1:0]   w_e_shift;
    logic                   w_e_bit;
    logic                   w_op_active;
    logic                   w_req;
    logic                   w_ack;
    logic                   w_cap;
    logic [WIDTH-1:0]       w_op_a;
    logic [WIDTH-1:0]       w_op_b;
    logic [WIDTH-1:0]       w_mm_res;

    assign w_t_clamp   = (in_t > C_T_MAX) ? C_T_MAX : in_t;
    assign w_i_dec     = r_i - C_IDX_ONE;
    assign w_e_shift   = r_e >> w_i_dec;
    assign w_e_bit     = w_e_shift[0];
    assign w_op_active = (r_state == ST_PRE) || (r_state == ST_SQR) ||
                         (r_state == ST_MUL) || (r_state == ST_POST);
    assign w_req       = w_op_active && (r_phase == PH_ISSUE);
    assign w_cap       = w_ack && (r_phase == PH_WAIT);

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        case (r_state)
            ST_PRE:  begin w_op_a = r_x;   w_op_b = r_r2;  end
            ST_SQR:  begin w_op_a = r_acc; w_op_b = r_acc; end
            ST_MUL:  begin w_op_a = r_acc; w_op_b = r_xm;  end
            ST_POST: begin w_op_a = r_acc; w_op_b = C_ONE; end
            default: ;
        endcase
    end

    mm_issue #(
        .WIDTH (WIDTH)
    ) u_issue (
        .clk         (clk),
        .resetn      (resetn),
        .i_req       (w_req),
        .i_a         (w_op_a),
        .i_b         (w_op_b),
        .i_m         (r_m),
        .o_mm_start  (mm_start),
        .o_mm_a      (mm_a),
        .o_mm_b      (mm_b),
        .o_mm_m      (mm_m),
        .i_mm_result (mm_result),
        .i_mm_done   (mm_done),
        .o_ack       (w_ack),
        .o_result    (w_mm_res)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_phase <= PH_ISSUE;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_PRE;
                    w_phase_nxt = PH_ISSUE;
                end
            end
            ST_PRE, ST_SQR, ST_MUL, ST_POST: begin
                if (r_phase == PH_ISSUE) begin
                    w_phase_nxt = PH_WAIT;
                end else if (w_cap) begin
                    w_phase_nxt = PH_ISSUE;
                    case (r_state)
                        ST_PRE, ST_MUL: w_state_nxt = (r_i != '0) ? ST_SQR : ST_POST;
                        ST_SQR: begin
                            // Bit select uses the index after this squaring's decrement.
                            if (r_i == '0)         w_state_nxt = ST_POST;
                            else if (w_e_bit)      w_state_nxt = ST_MUL;
                            else if (w_i_dec != '0) w_state_nxt = ST_SQR;
                            else                   w_state_nxt = ST_POST;
                        end
                        default: w_state_nxt = ST_DONE;
                    endcase
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: begin
                w_state_nxt = ST_IDLE;
                w_phase_nxt = PH_ISSUE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x      <= '0;
            r_e      <= '0;
            r_m      <= '0;
            r_r2     <= '0;
            r_acc    <= '0;
            r_xm     <= '0;
            r_i      <= '0;
            r_result <= '0;
        end else if (r_state == ST_IDLE) begin
            if (start) begin
                r_x   <= in_x;
                r_e   <= in_e;
                r_m   <= in_m;
                r_r2  <= in_r2_mod_m;
                r_acc <= in_r_mod_m;
                r_i   <= w_t_clamp;
            end
        end else if (w_cap) begin
            case (r_state)
                ST_PRE:  r_xm <= w_mm_res;
                ST_SQR: begin
                    r_acc <= w_mm_res;
                    if (r_i != '0) r_i <= w_i_dec;
                end
                ST_MUL:  r_acc    <= w_mm_res;
                ST_POST: r_result <= w_mm_res;
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign done   = (r_state == ST_DONE);
    assign busy   = w_op_active;

endmodule

`default_nettype wire

// File: doc/modexp_ctrl.md
Name: modexp_ctrl

Overview:
- Sequencer that computes a modular exponentiation result = x^e mod M by repeatedly driving the 1024-bit Montgomery multiplier over its start/done handshake.
- Sits directly upstream of the multiplier and owns its operand buses.
- Uses left-to-right square-and-multiply with Montgomery-domain entry and exit conversions.
- The multiplier is instantiated by the parent. This block only exposes the request/response ports.

Parameters:
- WIDTH, 1024: operand/modulus width in bits; Montgomery R = 2^WIDTH.
- EXP_WIDTH, 1024: maximum exponent width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- in_x  in  WIDTH  base, normal domain, < M.
- in_e  in  EXP_WIDTH  exponent.
- in_t  in  clog2(EXP_WIDTH)+1  number of exponent bits to process, 0..EXP_WIDTH (bits t-1..0).
- in_m  in  WIDTH  odd modulus.
- in_r_mod_m  in  WIDTH  R mod M.
- in_r2_mod_m  in  WIDTH  R^2 mod M.
- mm_start  out  1  one-cycle pulse to the multiplier.
- mm_a, mm_b, mm_m  out  WIDTH each  multiplier operands; held stable from mm_start until mm_done.
- mm_result  in  WIDTH  multiplier output; valid when mm_done=1.
- mm_done  in  1  multiplier completion pulse.
- result  out  WIDTH  final x^e mod M.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after start is accepted until done.

Behaviour:
- Reset values (asynchronous, immediate on resetn=0): state=IDLE, mm_start=0, done=0, busy=0, result=0, mm_a/mm_b/mm_m=0, all internal registers 0.
- IDLE, start=1: latch in_x, in_e, in_t, in_m, in_r_mod_m, in_r2_mod_m; A := r_mod_m; i := t; go to PRE.
- Each operation uses an ISSUE cycle, then WAIT:
  - ISSUE: drive mm_a/mm_b, set mm_m=latched M, pulse mm_start=1 for exactly one cycle.
  - WAIT: hold the operands; on mm_done capture mm_result in the same edge.
- PRE: Mont(x, r2_mod_m) -> X~; then go to SQR if i>0, else POST.
- SQR: Mont(A, A) -> A; decrement i. If e[i] (the new i) = 1, go to MUL. Else go to SQR if i>0, else POST.
- MUL: Mont(A, X~) -> A; then go to SQR if i>0, else POST.
- POST: Mont(A, 1) -> result; go to DONE.
- DONE: done=1 for one cycle, busy=0; return to IDLE.
- result holds its value until the next POST capture. It is not cleared on start.
- Operation count = 2 + t + popcount(e[t-1:0]). Latency = sum of (1 issue + multiplier latency) over all ops, + 1 start cycle + 1 done cycle.
- Boundaries:
  - start while busy: ignored, latched operands unchanged.
  - start coincident with done: ignored; start is accepted only in IDLE.
  - mm_done outside WAIT: ignored.
  - mm_done in the ISSUE cycle: cannot legally occur; treat as not seen.
  - t=0: PRE then POST only; result = 1 mod M.
  - t>EXP_WIDTH: clamp to EXP_WIDTH at latch.
  - e=0 with t>0: t squarings, no MUL; result = 1.
  - Reset mid-operation: immediate return to IDLE with reset values. A late mm_done after reset is ignored.
- Index counter i must not underflow. Compare i>0 before decrementing; bit select is e[i-1] at the decrement edge.

Decomposition:
- Shared package modexp_pkg:
  - state encoding IDLE, PRE, SQR, MUL, POST, DONE, plus issue/wait sub-phase bit;
  - localparam IDX_W = clog2(EXP_WIDTH)+1.
- One natural sub-module: mm_issue, a small handshake helper. It takes an op request plus operands, produces the single-cycle mm_start, holds the operands, and returns captured mm_result with a one-cycle ack.
- Everything else stays in modexp_ctrl.

Test Plan:
- WIDTH=8, EXP_WIDTH=8, M=241, r_mod_m=15, r2_mod_m=225, x=5, e=0b1011, t=4, behavioural multiplier with 3-cycle latency -> 9 mm_start pulses in order PRE,SQR,MUL,SQR,SQR,MUL,SQR,MUL,POST; result=79; done pulses once.
- Same setup, t=0 -> exactly 2 mm_start pulses; result=1.
- Same setup, e=0, t=4 -> 6 ops with no MUL; result=1; busy high throughout, low on the cycle after done.
- Multiplier latency randomised 1..20 cycles per op, x=5, e=0b1011 -> result=79. Assert mm_a/mm_b/mm_m are stable from mm_start to mm_done. Assert mm_start never asserts twice without an intervening mm_done.
- start re-pulsed in the 4th op with x=7 -> ignored; result=79; spurious mm_done injected in SQR ISSUE -> ignored.
- resetn dropped during the 5th op's WAIT, then a late mm_done -> all outputs at reset values immediately, no done. A new start with x=5 then completes with result=79.
